// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue path: ALU control codes, ALUOp/funct values, FSM states.
package alu_issue_ctrl_pkg;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;

   typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode-side issue handshake, ALU operand/control bus and writeback handshake.
interface alu_issue_ctrl_if #(parameter int WIDTH = 32);

   logic             issue_valid;
   logic             issue_ready;
   logic [1:0]       alu_op;
   logic [5:0]       funct;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic [WIDTH-1:0] imm_ext;
   logic             use_imm;
   logic [4:0]       dest_reg;
   logic [WIDTH-1:0] read_data_1;
   logic [WIDTH-1:0] read_data_2;
   logic [3:0]       ALUcontrol;
   logic [WIDTH-1:0] alu_result;
   logic             wb_valid;
   logic             wb_ready;
   logic [WIDTH-1:0] wb_data;
   logic [4:0]       wb_reg;
   logic             wb_err;
   logic [15:0]      ops_done;
   logic [15:0]      ops_err;

   // master is the issue controller; slave is decode + ALU + writeback around it
   modport master (
      input  issue_valid, alu_op, funct, rs_data, rt_data, imm_ext, use_imm, dest_reg,
             alu_result, wb_ready,
      output issue_ready, read_data_1, read_data_2, ALUcontrol,
             wb_valid, wb_data, wb_reg, wb_err, ops_done, ops_err
   );

   modport slave (
      output issue_valid, alu_op, funct, rs_data, rt_data, imm_ext, use_imm, dest_reg,
             alu_result, wb_ready,
      input  issue_ready, read_data_1, read_data_2, ALUcontrol,
             wb_valid, wb_data, wb_reg, wb_err, ops_done, ops_err
   );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct to 4-bit ALU control translation with illegal-op flag.
module alu_ctrl_decode
   import alu_issue_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_ctrl,
   output logic       illegal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = 1'b0;
      case (alu_op)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: alu_ctrl = ALU_ADD;
               FUNCT_SUB: alu_ctrl = ALU_SUB;
               FUNCT_AND: alu_ctrl = ALU_AND;
               FUNCT_OR:  alu_ctrl = ALU_OR;
               default:   illegal  = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one decoded op, drives the registered-output ALU,
// waits out its latency and hands the captured result to writeback.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int ALU_LATENCY = 1
)(
   input  logic             clk,
   input  logic             rst,
   alu_issue_ctrl_if.master bus
);

   localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY - 1);

   state_t     state;
   logic [2:0] cnt;
   logic [3:0] dec_ctrl;
   logic       dec_illegal;

   alu_ctrl_decode u_dec (
      .alu_op   (bus.alu_op),
      .funct    (bus.funct),
      .alu_ctrl (dec_ctrl),
      .illegal  (dec_illegal)
   );

   assign bus.issue_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= 3'd0;
         bus.read_data_1 <= {WIDTH{1'b0}};
         bus.read_data_2 <= {WIDTH{1'b0}};
         bus.ALUcontrol  <= ALU_ADD;
         bus.wb_valid    <= 1'b0;
         bus.wb_data     <= {WIDTH{1'b0}};
         bus.wb_reg      <= 5'd0;
         bus.wb_err      <= 1'b0;
         bus.ops_done    <= 16'd0;
         bus.ops_err     <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.issue_valid) begin
                  bus.wb_reg <= bus.dest_reg;
                  // illegal ops bypass the ALU entirely, leaving its inputs untouched
                  if (dec_illegal) begin
                     bus.wb_err   <= 1'b1;
                     bus.wb_data  <= {WIDTH{1'b0}};
                     bus.ops_err  <= bus.ops_err + 16'd1;
                     bus.wb_valid <= 1'b1;
                     state        <= RESP;
                  end else begin
                     bus.read_data_1 <= bus.rs_data;
                     bus.read_data_2 <= bus.use_imm ? bus.imm_ext : bus.rt_data;
                     bus.ALUcontrol  <= dec_ctrl;
                     state           <= EXEC;
                  end
               end
            end
            EXEC: begin
               cnt   <= CNT_INIT;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  bus.wb_data  <= bus.alu_result;
                  bus.wb_err   <= 1'b0;
                  bus.ops_done <= bus.ops_done + 16'd1;
                  bus.wb_valid <= 1'b1;
                  state        <= RESP;
               end
            end
            RESP: begin
               if (bus.wb_ready) begin
                  bus.wb_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance at ALU_LATENCY=1 with a 1-stage ALU,
// one at ALU_LATENCY=3 with a 3-stage ALU.
module tb_alu_issue_ctrl;

   logic clk  = 1'b0;
   logic rst1 = 1'b0;
   logic rst3 = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl_if #(.WIDTH(32)) i1 ();
   alu_issue_ctrl_if #(.WIDTH(32)) i3 ();

   alu_issue_ctrl #(.WIDTH(32), .ALU_LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(i1.master));
   alu_issue_ctrl #(.WIDTH(32), .ALU_LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(i3.master));

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
      case (c)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         default: return 32'd0;
      endcase
   endfunction

   // ALU models with registered output: one stage and three stages
   logic [31:0] s1, s2;
   always @(posedge clk) i1.alu_result <= alu_f(i1.read_data_1, i1.read_data_2, i1.ALUcontrol);
   always @(posedge clk) begin
      s1            <= alu_f(i3.read_data_1, i3.read_data_2, i3.ALUcontrol);
      s2            <= s1;
      i3.alu_result <= s2;
   end

   task automatic issue1(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm, input logic ui,
                         input logic [4:0] dr);
      i1.alu_op = op; i1.funct = fn; i1.rs_data = rs; i1.rt_data = rt;
      i1.imm_ext = imm; i1.use_imm = ui; i1.dest_reg = dr; i1.issue_valid = 1'b1;
      @(posedge clk); #1;
      i1.issue_valid = 1'b0;
   endtask

   task automatic wait_wb1(output int lat);
      lat = 1;
      while (!i1.wb_valid && lat < 20) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic respond1();
      i1.wb_ready = 1'b1;
      @(posedge clk); #1;
      i1.wb_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst1 = 1'b1; rst3 = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst1 = 1'b0; rst3 = 1'b0;
      n_cmp++; if (i1.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", i1.issue_ready); end
      n_cmp++; if (i1.wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", i1.wb_valid); end
      n_cmp++; if (i1.ALUcontrol !== 4'd2) begin n_fail++; $display("FAIL rst_aluctrl: got %0d want 2", i1.ALUcontrol); end
      n_cmp++; if (i1.read_data_1 !== 32'd0) begin n_fail++; $display("FAIL rst_rd1: got %h want 0", i1.read_data_1); end
      n_cmp++; if (i1.read_data_2 !== 32'd0) begin n_fail++; $display("FAIL rst_rd2: got %h want 0", i1.read_data_2); end
      n_cmp++; if (i1.ops_done !== 16'd0) begin n_fail++; $display("FAIL rst_ops_done: got %0d want 0", i1.ops_done); end
      n_cmp++; if (i1.ops_err !== 16'd0) begin n_fail++; $display("FAIL rst_ops_err: got %0d want 0", i1.ops_err); end
      n_cmp++; if (i3.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst3_ready: got %b want 1", i3.issue_ready); end
   endtask

   task automatic test_rtype_add();
      int lat;
      issue1(2'b10, 6'h20, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3);
      wait_wb1(lat);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", lat); end
      n_cmp++; if (i1.wb_data !== 32'd12) begin n_fail++; $display("FAIL add_data: got %h want %h", i1.wb_data, 32'd12); end
      n_cmp++; if (i1.wb_reg !== 5'd3) begin n_fail++; $display("FAIL add_reg: got %0d want 3", i1.wb_reg); end
      n_cmp++; if (i1.wb_err !== 1'b0) begin n_fail++; $display("FAIL add_err: got %b want 0", i1.wb_err); end
      n_cmp++; if (i1.ops_done !== 16'd1) begin n_fail++; $display("FAIL add_ops_done: got %0d want 1", i1.ops_done); end
      n_cmp++; if (i1.ALUcontrol !== 4'd2) begin n_fail++; $display("FAIL add_aluctrl: got %0d want 2", i1.ALUcontrol); end
      n_cmp++; if (i1.read_data_2 !== 32'd7) begin n_fail++; $display("FAIL add_rd2: got %h want 7", i1.read_data_2); end
      respond1();
      n_cmp++; if (i1.wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_wb_drop: got %b want 0", i1.wb_valid); end
      n_cmp++; if (i1.issue_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_back: got %b want 1", i1.issue_ready); end
   endtask

   task automatic test_sub_wrap_and_imm();
      int lat;
      issue1(2'b01, 6'h00, 32'd0, 32'd1, 32'd0, 1'b0, 5'd4);
      wait_wb1(lat);
      n_cmp++; if (i1.wb_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_data: got %h want ffffffff", i1.wb_data); end
      n_cmp++; if (i1.ALUcontrol !== 4'd6) begin n_fail++; $display("FAIL sub_aluctrl: got %0d want 6", i1.ALUcontrol); end
      respond1();
      issue1(2'b10, 6'h24, 32'hF0F0_F0F0, 32'h1234_5678, 32'h0000_FFFF, 1'b1, 5'd9);
      wait_wb1(lat);
      n_cmp++; if (i1.wb_data !== 32'h0000_F0F0) begin n_fail++; $display("FAIL andi_data: got %h want 0000f0f0", i1.wb_data); end
      n_cmp++; if (i1.read_data_2 !== 32'h0000_FFFF) begin n_fail++; $display("FAIL andi_rd2: got %h want 0000ffff", i1.read_data_2); end
      n_cmp++; if (i1.ALUcontrol !== 4'd0) begin n_fail++; $display("FAIL andi_aluctrl: got %0d want 0", i1.ALUcontrol); end
      n_cmp++; if (i1.wb_reg !== 5'd9) begin n_fail++; $display("FAIL andi_reg: got %0d want 9", i1.wb_reg); end
      n_cmp++; if (i1.ops_done !== 16'd3) begin n_fail++; $display("FAIL andi_ops_done: got %0d want 3", i1.ops_done); end
      respond1();
   endtask

   task automatic test_illegal();
      int lat;
      issue1(2'b10, 6'h2A, 32'd1, 32'd2, 32'd0, 1'b0, 5'd7);
      wait_wb1(lat);
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ill_latency: got %0d want 1", lat); end
      n_cmp++; if (i1.wb_err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b want 1", i1.wb_err); end
      n_cmp++; if (i1.wb_data !== 32'd0) begin n_fail++; $display("FAIL ill_data: got %h want 0", i1.wb_data); end
      n_cmp++; if (i1.wb_reg !== 5'd7) begin n_fail++; $display("FAIL ill_reg: got %0d want 7", i1.wb_reg); end
      n_cmp++; if (i1.ops_err !== 16'd1) begin n_fail++; $display("FAIL ill_ops_err: got %0d want 1", i1.ops_err); end
      n_cmp++; if (i1.ops_done !== 16'd3) begin n_fail++; $display("FAIL ill_ops_done: got %0d want 3", i1.ops_done); end
      n_cmp++; if (i1.read_data_1 !== 32'hF0F0_F0F0) begin n_fail++; $display("FAIL ill_rd1_held: got %h want f0f0f0f0", i1.read_data_1); end
      n_cmp++; if (i1.ALUcontrol !== 4'd0) begin n_fail++; $display("FAIL ill_aluctrl_held: got %0d want 0", i1.ALUcontrol); end
      respond1();
      issue1(2'b11, 6'h20, 32'd1, 32'd2, 32'd0, 1'b0, 5'd8);
      wait_wb1(lat);
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL rsvd_latency: got %0d want 1", lat); end
      n_cmp++; if (i1.ops_err !== 16'd2) begin n_fail++; $display("FAIL rsvd_ops_err: got %0d want 2", i1.ops_err); end
      respond1();
   endtask

   task automatic test_backpressure();
      int lat;
      issue1(2'b00, 6'h00, 32'd100, 32'd23, 32'd0, 1'b0, 5'd5);
      wait_wb1(lat);
      n_cmp++; if (i1.wb_data !== 32'd123) begin n_fail++; $display("FAIL bp_data: got %0d want 123", i1.wb_data); end
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            i1.alu_op = 2'b00; i1.rs_data = 32'd1; i1.rt_data = 32'd1; i1.issue_valid = 1'b1;
         end
         @(posedge clk); #1;
         i1.issue_valid = 1'b0;
         n_cmp++; if (i1.wb_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b want 1", c, i1.wb_valid); end
         n_cmp++; if (i1.wb_data !== 32'd123) begin n_fail++; $display("FAIL bp_hold_c%0d: got %0d want 123", c, i1.wb_data); end
         n_cmp++; if (i1.issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b want 0", c, i1.issue_ready); end
      end
      respond1();
      n_cmp++; if (i1.wb_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", i1.wb_valid); end
      n_cmp++; if (i1.issue_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", i1.issue_ready); end
      n_cmp++; if (i1.read_data_1 !== 32'd100) begin n_fail++; $display("FAIL bp_ignored_issue: got %0d want 100", i1.read_data_1); end
      n_cmp++; if (i1.ops_done !== 16'd4) begin n_fail++; $display("FAIL bp_ops_done: got %0d want 4", i1.ops_done); end
   endtask

   task automatic test_reset_midop();
      logic seen;
      issue1(2'b00, 6'h00, 32'd8, 32'd9, 32'd0, 1'b0, 5'd6);
      @(posedge clk); #1;
      rst1 = 1'b1;
      @(posedge clk); #1;
      rst1 = 1'b0;
      n_cmp++; if (i1.wb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_wb_valid: got %b want 0", i1.wb_valid); end
      n_cmp++; if (i1.read_data_1 !== 32'd0) begin n_fail++; $display("FAIL mid_rd1: got %h want 0", i1.read_data_1); end
      n_cmp++; if (i1.read_data_2 !== 32'd0) begin n_fail++; $display("FAIL mid_rd2: got %h want 0", i1.read_data_2); end
      n_cmp++; if (i1.ALUcontrol !== 4'd2) begin n_fail++; $display("FAIL mid_aluctrl: got %0d want 2", i1.ALUcontrol); end
      n_cmp++; if (i1.wb_data !== 32'd0) begin n_fail++; $display("FAIL mid_wb_data: got %h want 0", i1.wb_data); end
      n_cmp++; if (i1.wb_reg !== 5'd0) begin n_fail++; $display("FAIL mid_wb_reg: got %0d want 0", i1.wb_reg); end
      n_cmp++; if (i1.ops_done !== 16'd0) begin n_fail++; $display("FAIL mid_ops_done: got %0d want 0", i1.ops_done); end
      n_cmp++; if (i1.ops_err !== 16'd0) begin n_fail++; $display("FAIL mid_ops_err: got %0d want 0", i1.ops_err); end
      n_cmp++; if (i1.issue_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", i1.issue_ready); end
      seen = 1'b0;
      repeat (5) begin @(posedge clk); #1; if (i1.wb_valid) seen = 1'b1; end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_wb: got %b want 0", seen); end
   endtask

   task automatic test_latency3();
      int lat;
      i3.alu_op = 2'b10; i3.funct = 6'h25; i3.rs_data = 32'h0F; i3.rt_data = 32'hF0;
      i3.imm_ext = 32'd0; i3.use_imm = 1'b0; i3.dest_reg = 5'd1; i3.issue_valid = 1'b1;
      @(posedge clk); #1;
      i3.issue_valid = 1'b0;
      lat = 1;
      while (!i3.wb_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL lat3_latency: got %0d want 5", lat); end
      n_cmp++; if (i3.wb_data !== 32'hFF) begin n_fail++; $display("FAIL lat3_data: got %h want ff", i3.wb_data); end
      n_cmp++; if (i3.ALUcontrol !== 4'd1) begin n_fail++; $display("FAIL lat3_aluctrl: got %0d want 1", i3.ALUcontrol); end
      n_cmp++; if (i3.ops_done !== 16'd1) begin n_fail++; $display("FAIL lat3_ops_done: got %0d want 1", i3.ops_done); end
      i3.wb_ready = 1'b1;
      @(posedge clk); #1;
      i3.wb_ready = 1'b0;
      n_cmp++; if (i3.wb_valid !== 1'b0) begin n_fail++; $display("FAIL lat3_wb_drop: got %b want 0", i3.wb_valid); end
   endtask

   initial begin
      i1.issue_valid = 1'b0; i1.alu_op = 2'b00; i1.funct = 6'h00; i1.rs_data = 32'd0;
      i1.rt_data = 32'd0; i1.imm_ext = 32'd0; i1.use_imm = 1'b0; i1.dest_reg = 5'd0;
      i1.wb_ready = 1'b0;
      i3.issue_valid = 1'b0; i3.alu_op = 2'b00; i3.funct = 6'h00; i3.rs_data = 32'd0;
      i3.rt_data = 32'd0; i3.imm_ext = 32'd0; i3.use_imm = 1'b0; i3.dest_reg = 5'd0;
      i3.wb_ready = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_rtype_add();
      test_sub_wrap_and_imm();
      test_illegal();
      test_backpressure();
      test_reset_midop();
      test_latency3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU datapath interface. It accepts one decoded instruction at a time over a valid/ready handshake and translates ALUOp/funct into the 4-bit ALU control code. It drives the ALU operand and control inputs, waits out the ALU's registered-output latency, captures the result, and presents it to writeback over a second valid/ready handshake. It sits between the decode stage and the ALU in the multi-cycle CPU.

Parameters:
WIDTH, 32, operand/result width
ALU_LATENCY, 1, clock edges between stable ALU inputs and a valid ALU result (1..7)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
issue_valid  in  1  instruction offered
issue_ready  out  1  block can accept (high only in IDLE)
alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved
funct  in  6  R-type function field
rs_data  in  WIDTH  first operand
rt_data  in  WIDTH  second operand (register)
imm_ext  in  WIDTH  sign-extended immediate
use_imm  in  1  1: second operand = imm_ext
dest_reg  in  5  writeback register index
read_data_1  out  WIDTH  ALU operand A
read_data_2  out  WIDTH  ALU operand B
ALUcontrol  out  4  ALU op code: 0 AND, 1 OR, 2 ADD, 6 SUB
alu_result  in  WIDTH  registered ALU output
wb_valid  out  1  result available
wb_ready  in  1  writeback accepts
wb_data  out  WIDTH  captured result (0 on error)
wb_reg  out  5  dest_reg of the instruction
wb_err  out  1  illegal operation flag
ops_done  out  16  count of completed legal ops, wraps
ops_err  out  16  count of illegal ops, wraps

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). On rst: state=IDLE, read_data_1/2=0, ALUcontrol=2, wb_valid=0, wb_data=0, wb_reg=0, wb_err=0, ops_done=0, ops_err=0, wait counter=0. Reset mid-operation abandons the op and produces no wb_valid.
- Decode is combinational from alu_op/funct: 00->2; 01->6; 10 with funct 0x20->2, 0x22->6, 0x24->0, 0x25->1; any other funct, or alu_op=11 -> illegal.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE: issue_ready=1. On issue_valid, the legal-op path registers read_data_1=rs_data, read_data_2=(use_imm?imm_ext:rt_data), ALUcontrol=decoded code, and wb_reg=dest_reg, then goes to EXEC. The illegal path sets wb_err=1, wb_data=0, and wb_reg=dest_reg, increments ops_err, and goes to RESP with no ALU activity.
- EXEC: ALU inputs stable for one edge. Load counter=ALU_LATENCY-1 and go to WAIT.
- WAIT: while counter!=0, decrement. When counter==0, capture wb_data=alu_result, wb_err=0, increment ops_done, and go to RESP.
- Accept-to-wb_valid latency for a legal op is ALU_LATENCY+2 cycles (3 at default). For an illegal op it is 1 cycle.
- RESP: wb_valid=1. wb_data/wb_reg/wb_err are held stable until wb_ready is sampled high. Then wb_valid drops and the FSM goes to IDLE. The next issue is acceptable on the following edge, so there is no same-cycle turnaround.
- read_data_1/2 and ALUcontrol hold their values from IDLE-accept until the next accept. They never change in EXEC, WAIT or RESP.
- Arithmetic is performed by the ALU, modulo 2^WIDTH. No overflow detection here.
- The counters wrap from 0xFFFF to 0x0000 silently.
- issue_valid outside IDLE is ignored. Inputs need only be stable in the accepting cycle.

Decomposition:
- Shared package: ALU control code constants (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6), ALUOp encodings, funct constants (0x20/0x22/0x24/0x25), and the FSM state enum.
- One natural sub-module: alu_ctrl_decode (combinational alu_op+funct -> {ALUcontrol, illegal}). It is reusable by the single-cycle path.

Test Plan:
- Reset then idle: rst for 2 cycles -> issue_ready=1, wb_valid=0, ALUcontrol=2, read_data_1/2=0, counters=0.
- R-type ADD: alu_op=10, funct=0x20, rs=5, rt=7, dest_reg=3, with a real ALU attached -> wb_valid 3 cycles after accept, wb_data=12, wb_reg=3, wb_err=0, ops_done=1.
- SUB wrap plus immediate AND: alu_op=01, rs=0, rt=1 -> wb_data=0xFFFFFFFF. Then alu_op=10, funct=0x24, use_imm=1, rs=0xF0F0_F0F0, imm=0x0000_FFFF -> wb_data=0x0000_F0F0.
- Illegal op: alu_op=10, funct=0x2A -> wb_valid 1 cycle after accept, wb_err=1, wb_data=0, ops_err=1, ALU inputs unchanged.
- Writeback backpressure: hold wb_ready=0 for 5 cycles during RESP -> wb_valid/wb_data stable, issue_ready=0, and an issue_valid pulse is ignored. Raising wb_ready gives wb_valid=0 and issue_ready=1 on the next cycle.
- Reset mid-op and latency: assert rst in WAIT -> no wb_valid, all outputs at reset values. With ALU_LATENCY=3 and a 3-stage ALU model, OR of 0x0F and 0xF0 -> wb_data=0xFF, 5 cycles after accept.
